// File: rtl/dynamic_node_pkg.sv
// Shared definitions for the dynamic node output path: arbiter state
// encoding, header length-field defaults and the header length extractor.
// No ports; imported by dynamic_output_arb_mux and dynamic_rr_pick.
package dynamic_node_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,   // waiting for a header, round-robin among channels
    ST_BODY = 1'b1    // wormhole-locked on one channel for body flits
  } arb_state_e;

  localparam int unsigned LEN_LSB_DEF = 22;
  localparam int unsigned LEN_W_DEF   = 8;

  // The extractor works on a fixed maximum flit/length width so it can be
  // shared by any instance; callers zero-extend the flit and truncate the
  // result to their own length width.
  localparam int unsigned FLIT_MAX_W = 512;
  localparam int unsigned LEN_MAX_W  = 16;

  function automatic logic [LEN_MAX_W-1:0] hdr_len(
    input logic [FLIT_MAX_W-1:0] flit,
    input int unsigned           lsb,
    input int unsigned           w
  );
    logic [FLIT_MAX_W-1:0] shifted;
    logic [LEN_MAX_W-1:0]  mask;
    shifted = flit >> lsb;
    // w == LEN_MAX_W wraps the shifted one to zero, giving an all-ones mask
    mask    = (LEN_MAX_W'(1) << w) - LEN_MAX_W'(1);
    return shifted[LEN_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/dynamic_rr_pick.sv
// Round-robin picker: first requesting channel at or after rr_ptr, scanning
// upward with wrap-around. Purely combinational.
// Ports: req (request vector), rr_ptr (scan start), grant (one-hot), grant_idx (binary).
module dynamic_rr_pick #(
  parameter  int NUM_IN = 8,
  localparam int IW     = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IW-1:0]     rr_ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [IW-1:0]     grant_idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      // explicit wrap compare keeps non-power-of-two NUM_IN correct
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_IN)) begin
        sum = sum - (IW+1)'(NUM_IN);
      end
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dynamic_output_arb_mux.sv
// Wormhole output arbiter/mux: round-robin among input headers, locks the
// winner for its body flits, registered output with valid/yummy credit flow.
// Ports: clk, rst_n, in_data/in_valid/in_yummy (N inputs), out_data/out_valid/out_yummy.
// Optional DYNAMIC_OUTPUT_ARB_STATS_EN adds pkt_count and stall_count outputs.
module dynamic_output_arb_mux
  import dynamic_node_pkg::*;
#(
  parameter int NUM_IN  = 8,
  parameter int WIDTH   = 64,
  parameter int LEN_LSB = LEN_LSB_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CREDITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_yummy,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_yummy
`ifdef DYNAMIC_OUTPUT_ARB_STATS_EN
  ,
  output logic [31:0]             pkt_count,
  output logic [31:0]             stall_count
`endif
);

  localparam int IW = $clog2(NUM_IN);
  localparam int CW = $clog2(CREDITS + 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     lock_q, lock_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;

  logic [NUM_IN-1:0] pick_grant;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     sel_idx;
  logic [NUM_IN-1:0] sel_onehot;
  logic              cand_vld;
  logic              has_credit;
  logic              send;
  logic [WIDTH-1:0]  sel_flit;
  logic [LEN_W-1:0]  hdr_l;

  dynamic_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req       (in_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  // Send decision depends only on registered state, credit and in_valid,
  // so out_yummy never reaches in_yummy in the same cycle.
  always_comb begin
    sel_idx    = pick_idx;
    sel_onehot = pick_grant;
    cand_vld   = |in_valid;
    if (state_q == ST_BODY) begin
      sel_idx    = lock_q;
      sel_onehot = NUM_IN'(1) << lock_q;
      cand_vld   = in_valid[lock_q];
    end
    has_credit = (credit_q != '0);
    send       = cand_vld && has_credit;
    in_yummy   = send ? sel_onehot : '0;
  end

  assign sel_flit = in_data[sel_idx*WIDTH +: WIDTH];
  assign hdr_l    = LEN_W'(hdr_len(FLIT_MAX_W'(sel_flit), LEN_LSB, LEN_W));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (send) begin
          lock_d   = pick_idx;
          rr_ptr_d = (pick_idx == IW'(NUM_IN - 1)) ? '0 : pick_idx + 1'b1;
          if (hdr_l != '0) begin
            state_d     = ST_BODY;
            remaining_d = hdr_l;
          end
        end
      end
      ST_BODY: begin
        if (send) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    if (send && !out_yummy) begin
      credit_d = credit_q - 1'b1;
    end else if (!send && out_yummy && credit_q != CW'(CREDITS)) begin
      // saturate; a surplus return is flagged by the assertion below
      credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      lock_q      <= '0;
      remaining_q <= '0;
      credit_q    <= CW'(CREDITS);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      remaining_q <= remaining_d;
      credit_q    <= credit_d;
      out_valid_q <= send;
      if (send) begin
        out_data_q <= sel_flit;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  credit_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(out_yummy && !send && credit_q == CW'(CREDITS)));

`ifdef DYNAMIC_OUTPUT_ARB_STATS_EN
  logic [31:0] pkt_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (send && state_q == ST_IDLE) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
      if (cand_vld && !has_credit && stall_count_q != '1) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`else
  // statistics counters not built
`endif

endmodule

// File: tb/tb_dynamic_output_arb_mux.sv
// Directed bench for dynamic_output_arb_mux: round robin, wormhole lock,
// credit stall/return, async reset mid-packet, optional statistics.
module tb_dynamic_output_arb_mux;

  localparam int NUM_IN  = 8;
  localparam int W       = 64;
  localparam int CREDITS = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_IN*W-1:0] in_data = '0;
  logic [NUM_IN-1:0]   in_valid = '0;
  logic [NUM_IN-1:0]   in_yummy;
  logic [W-1:0]        out_data;
  logic                out_valid;
  logic                out_yummy = 1'b0;
`ifdef DYNAMIC_OUTPUT_ARB_STATS_EN
  logic [31:0]         pkt_count;
  logic [31:0]         stall_count;
`endif

  int n_chk = 0;
  int n_bad = 0;
  bit ds_auto = 1'b0;   // downstream returns a credit the cycle after each flit

  always #5 clk = ~clk;

  dynamic_output_arb_mux #(
    .NUM_IN(NUM_IN), .WIDTH(W), .LEN_LSB(22), .LEN_W(8), .CREDITS(CREDITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_yummy  (in_yummy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_yummy (out_yummy)
`ifdef DYNAMIC_OUTPUT_ARB_STATS_EN
    ,
    .pkt_count   (pkt_count),
    .stall_count (stall_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int ch, input int len, input int seq);
    logic [63:0] r;
    r        = '0;
    r[63:56] = 8'(ch);
    r[29:22] = 8'(len);
    r[15:0]  = 16'(seq);
    return r;
  endfunction

  task automatic set_ch(input int ch, input logic [63:0] v);
    in_data[ch*W +: W] = v;
  endtask

  // Drive one cycle: apply inputs, check the combinational yummy, clock, settle.
  task automatic step(input string tag, input logic [NUM_IN-1:0] v, input logic oy,
                      input logic [NUM_IN-1:0] exp_y);
    in_valid  = v;
    out_yummy = oy | (ds_auto & out_valid);
    #1;
    check({tag, "_yummy"}, 64'(in_yummy), 64'(exp_y));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_yummy = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[6];
    logic [63:0] f[10];
    order = '{0, 3, 7, 0, 3, 7};
    f[0] = mk(1, 9, 0);
    for (int i = 1; i < 10; i++) f[i] = mk(1, 8'hAA, i);

    // ---- reset state ----
    do_reset();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_yummy", 64'(in_yummy), 64'd0);

    // ---- single-flit round robin over channels 0,3,7 ----
    ds_auto = 1'b1;
    set_ch(0, mk(0, 0, 0));
    set_ch(3, mk(3, 0, 0));
    set_ch(7, mk(7, 0, 0));
    for (int k = 0; k < 6; k++) begin
      step($sformatf("rr%0d", k), 8'h89, 1'b0, NUM_IN'(1) << order[k]);
      check($sformatf("rr%0d_vld", k), 64'(out_valid), 64'd1);
      check($sformatf("rr%0d_dat", k), out_data, mk(order[k], 0, 0));
    end
    step("rr_idle", 8'h00, 1'b0, 8'h00);
    check("rr_idle_vld", 64'(out_valid), 64'd0);

    // ---- wormhole lock: ch2 L=3 with ch5 waiting ----
    do_reset();
    ds_auto = 1'b1;
    set_ch(2, mk(2, 3, 0));
    set_ch(5, mk(5, 0, 0));
    step("wh_hdr", 8'h24, 1'b0, 8'h04);
    check("wh_hdr_dat", out_data, mk(2, 3, 0));
    for (int b = 1; b <= 3; b++) begin
      set_ch(2, mk(2, 8'hAA, b));
      step($sformatf("wh_body%0d", b), 8'h24, 1'b0, 8'h04);
      check($sformatf("wh_body%0d_dat", b), out_data, mk(2, 8'hAA, b));
    end
    step("wh_ch5", 8'h20, 1'b0, 8'h20);
    check("wh_ch5_dat", out_data, mk(5, 0, 0));

    // ---- credit stall: 4 credits, no returns, then one pulse ----
    do_reset();
    ds_auto = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_ch(1, f[c]);
      step($sformatf("cs%0d", c), 8'h02, 1'b0, 8'h02);
      check($sformatf("cs%0d_dat", c), out_data, f[c]);
    end
    set_ch(1, f[4]);
    step("cs_stall0", 8'h02, 1'b0, 8'h00);
    check("cs_stall0_vld", 64'(out_valid), 64'd0);
    step("cs_ret", 8'h02, 1'b1, 8'h00);
    check("cs_ret_vld", 64'(out_valid), 64'd0);
    step("cs_rel", 8'h02, 1'b0, 8'h02);
    check("cs_rel_vld", 64'(out_valid), 64'd1);
    check("cs_rel_dat", out_data, f[4]);
    set_ch(1, f[5]);
    step("cs_stall1", 8'h02, 1'b0, 8'h00);
    check("cs_stall1_vld", 64'(out_valid), 64'd0);

    // ---- simultaneous send and credit return at credit=1 ----
    do_reset();
    ds_auto = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_ch(1, f[c]);
      step($sformatf("sim%0d", c), 8'h02, 1'b0, 8'h02);
    end
    set_ch(1, f[3]);
    step("sim_both", 8'h02, 1'b1, 8'h02);
    check("sim_both_dat", out_data, f[3]);
    set_ch(1, f[4]);
    step("sim_next", 8'h02, 1'b0, 8'h02);
    check("sim_next_dat", out_data, f[4]);
    set_ch(1, f[5]);
    step("sim_empty", 8'h02, 1'b0, 8'h00);
    check("sim_empty_vld", 64'(out_valid), 64'd0);

    // ---- reset mid-packet (remaining=2) ----
    do_reset();
    ds_auto = 1'b1;
    set_ch(1, mk(1, 3, 0));
    step("rm_hdr", 8'h02, 1'b0, 8'h02);
    set_ch(1, mk(1, 8'hAA, 1));
    step("rm_body1", 8'h02, 1'b0, 8'h02);
    check("rm_body1_vld", 64'(out_valid), 64'd1);
    rst_n     = 1'b0;
    in_valid  = '0;
    out_yummy = 1'b0;
    #1;
    check("rm_async_vld", 64'(out_valid), 64'd0);
    check("rm_async_dat", out_data, 64'd0);
    check("rm_async_yummy", 64'(in_yummy), 64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    ds_auto = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_ch(6, mk(6, 0, k));
      step($sformatf("rm_new%0d", k), 8'h40, 1'b0, 8'h40);
      check($sformatf("rm_new%0d_dat", k), out_data, mk(6, 0, k));
    end
    step("rm_cred", 8'h40, 1'b0, 8'h00);
    check("rm_cred_vld", 64'(out_valid), 64'd0);

`ifdef DYNAMIC_OUTPUT_ARB_STATS_EN
    // ---- statistics: 5 headers, 3 credit-starved cycles ----
    do_reset();
    ds_auto = 1'b0;
    set_ch(0, mk(0, 0, 0));
    for (int k = 0; k < 4; k++) step($sformatf("st_send%0d", k), 8'h01, 1'b0, 8'h01);
    for (int k = 0; k < 3; k++) step($sformatf("st_stall%0d", k), 8'h01, 1'b0, 8'h00);
    step("st_ret", 8'h00, 1'b1, 8'h00);
    step("st_send4", 8'h01, 1'b0, 8'h01);
    in_valid = '0;
    #1;
    check("st_pkt_count", 64'(pkt_count), 64'd5);
    check("st_stall_count", 64'(stall_count), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
